// File: rtl/mux4_packet_arbiter_if.sv
// Handshake bundle between four requesters, the downstream sink and the arbiter.
// Signal names follow the arbiter's point of view; the slave modport is the arbiter.
interface mux4_packet_arbiter_if;
  logic [3:0] valid_i;
  logic [3:0] last_i;
  logic [3:0] ready_o;
  logic [1:0] sel_o;
  logic [3:0] grant_o;
  logic       valid_o;
  logic       last_o;
  logic       ready_i;
  logic       busy_o;

  modport slave (
    input  valid_i,
    input  last_i,
    input  ready_i,
    output ready_o,
    output sel_o,
    output grant_o,
    output valid_o,
    output last_o,
    output busy_o
  );

  modport master (
    output valid_i,
    output last_i,
    output ready_i,
    input  ready_o,
    input  sel_o,
    input  grant_o,
    input  valid_o,
    input  last_o,
    input  busy_o
  );
endinterface

// File: rtl/mux4_packet_arbiter.sv
// Packet-level round-robin arbiter for a shared 4:1 select datapath.
// Grants are held until a packet's last beat or until MaxBeats transfers force release.
module mux4_packet_arbiter #(
  parameter int unsigned MaxBeats = 16,
  parameter int unsigned CntWidth = $clog2(MaxBeats + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  mux4_packet_arbiter_if.slave         bus
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MaxBeats - 1);

  state_e              r_state;
  logic [1:0]          r_sel;
  logic [3:0]          r_grant;
  logic [1:0]          r_ptr;
  logic [CntWidth-1:0] r_cnt;

  state_e              w_state_nxt;
  logic [1:0]          w_sel_nxt;
  logic [3:0]          w_grant_nxt;
  logic [1:0]          w_ptr_nxt;
  logic [CntWidth-1:0] w_cnt_nxt;

  logic [1:0]          w_winner;
  logic [1:0]          w_idx;
  logic                w_found;
  logic                w_valid;
  logic                w_last;
  logic [3:0]          w_ready;
  logic                w_xfer;
  logic                w_release;

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = '0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && bus.valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Handshake routing; everything is held off while reset is asserted.
  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_ready = '0;
    if (!rst_i && r_state == StLocked) begin
      w_valid        = bus.valid_i[r_sel];
      w_last         = bus.last_i[r_sel];
      w_ready[r_sel] = bus.ready_i;
    end
    w_xfer    = w_valid & bus.ready_i;
    w_release = w_xfer & (w_last | (r_cnt == LastCnt));
  end

  // Next-state logic: grant from IDLE, count beats and release from LOCKED.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt = StLocked;
          w_sel_nxt   = w_winner;
          w_grant_nxt = 4'b0001 << w_winner;
          w_cnt_nxt   = '0;
        end
      end
      StLocked: begin
        if (w_release) begin
          // sel is left alone so the external mux select never glitches on release
          w_state_nxt = StIdle;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = r_sel + 2'd1;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.valid_o = w_valid;
  assign bus.last_o  = w_last;
  assign bus.ready_o = w_ready;
  assign bus.sel_o   = r_sel;
  assign bus.grant_o = r_grant;
  assign bus.busy_o  = (r_state == StLocked);

endmodule

// File: tb/tb_mux4_packet_arbiter.sv
// Scoreboard bench for mux4_packet_arbiter (MaxBeats = 4).
// Stimulus pushes expected grants and beats; a negedge monitor pops and compares them.
module tb_mux4_packet_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] exp_grant[$];
  logic [2:0] exp_beat[$];   // {sel, last}
  logic [3:0] prev_grant = '0;

  always #5 clk = ~clk;

  mux4_packet_arbiter_if bus ();

  mux4_packet_arbiter #(
    .MaxBeats (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; the call returns at the following
  // falling edge, where the values seen are the ones the next rising edge acts on.
  task automatic tick(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic rd);
    @(posedge clk);
    #1;
    rst         = r;
    bus.valid_i = v;
    bus.last_i  = l;
    bus.ready_i = rd;
    @(negedge clk);
  endtask

  // Monitor: new grants and completed beats are checked against the queues.
  always @(negedge clk) begin
    logic [1:0] eg;
    logic [2:0] eb;
    if (!rst) begin
      if (bus.grant_o != prev_grant && bus.grant_o != 4'b0000) begin
        if (exp_grant.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got grant %b, none expected at %0t",
                   bus.grant_o, $time);
        end else begin
          eg = exp_grant.pop_front();
          chk("grant_sel", 32'(bus.sel_o), 32'(eg));
          chk("grant_onehot", 32'(bus.grant_o), 32'(4'b0001 << eg));
        end
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_beat.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got sel %0d last %0b, none expected at %0t",
                   bus.sel_o, bus.last_o, $time);
        end else begin
          eb = exp_beat.pop_front();
          chk("beat_sel_last", 32'({bus.sel_o, bus.last_o}), 32'(eb));
        end
      end
    end
    prev_grant = bus.grant_o;
  end

  initial begin
    bus.valid_i = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b0;

    // Test 1: reset values, then single-beat packet from requester 2.
    tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("rst_sel", 32'(bus.sel_o), 32'd0);
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_valid_ready", 32'({bus.valid_o, bus.ready_o}), 32'd0);
    chk("rst_ptr", 32'(dut.r_ptr), 32'd0);
    exp_grant.push_back(2'd2);
    exp_beat.push_back({2'd2, 1'b1});
    tick(1'b0, 4'b0100, 4'b0100, 1'b1);
    chk("t1_idle_ready", 32'(bus.ready_o), 32'd0);
    chk("t1_idle_valid", 32'(bus.valid_o), 32'd0);
    tick(1'b0, 4'b0100, 4'b0100, 1'b1);
    chk("t1_sel", 32'(bus.sel_o), 32'd2);
    chk("t1_ready", 32'(bus.ready_o), 32'b0100);
    chk("t1_busy", 32'(bus.busy_o), 32'd1);
    tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("t1_rel_busy", 32'(bus.busy_o), 32'd0);
    chk("t1_rel_ptr", 32'(dut.r_ptr), 32'd3);
    chk("t1_rel_sel_held", 32'(bus.sel_o), 32'd2);

    // Test 2: all requesters with one-beat packets from reset -> 0,1,2,3,0.
    tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int g = 0; g < 5; g++) begin
      exp_grant.push_back(2'(g % 4));
      exp_beat.push_back({2'(g % 4), 1'b1});
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'b1111, 4'b1111, 1'b1);
      chk("t2_busy_pattern", 32'(bus.busy_o), 32'(i % 2));
    end
    tick(1'b0, 4'b0000, 4'b0000, 1'b1);
    chk("t2_end_busy", 32'(bus.busy_o), 32'd0);
    chk("t2_end_ptr", 32'(dut.r_ptr), 32'd1);

    // Test 3: 6-beat packet from requester 1 split by the 4-beat limit.
    exp_grant.push_back(2'd1);
    exp_grant.push_back(2'd1);
    for (int b = 0; b < 5; b++) exp_beat.push_back({2'd1, 1'b0});
    exp_beat.push_back({2'd1, 1'b1});
    tick(1'b0, 4'b0010, 4'b0000, 1'b1);
    chk("t3_idle", 32'(bus.busy_o), 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick(1'b0, 4'b0010, 4'b0000, 1'b1);
      chk("t3_locked", 32'(bus.busy_o), 32'd1);
    end
    tick(1'b0, 4'b0010, 4'b0000, 1'b1);
    chk("t3_forced_release", 32'(bus.busy_o), 32'd0);
    chk("t3_forced_ptr", 32'(dut.r_ptr), 32'd2);
    tick(1'b0, 4'b0010, 4'b0000, 1'b1);
    chk("t3_regrant", 32'(bus.busy_o), 32'd1);
    tick(1'b0, 4'b0010, 4'b0010, 1'b1);
    chk("t3_last", 32'(bus.last_o), 32'd1);
    tick(1'b0, 4'b0000, 4'b0000, 1'b1);
    chk("t3_end_ptr", 32'(dut.r_ptr), 32'd2);

    // Test 4: requester 3 holds grant while its valid toggles; 0 and 2 also valid.
    exp_grant.push_back(2'd3);
    exp_beat.push_back({2'd3, 1'b0});
    exp_beat.push_back({2'd3, 1'b0});
    exp_beat.push_back({2'd3, 1'b1});
    tick(1'b0, 4'b1000, 4'b0000, 1'b1);
    chk("t4_idle", 32'(bus.busy_o), 32'd0);
    tick(1'b0, 4'b1101, 4'b0000, 1'b1);
    chk("t4_valid_hi", 32'(bus.valid_o), 32'd1);
    chk("t4_ready_only3", 32'(bus.ready_o), 32'b1000);
    tick(1'b0, 4'b0101, 4'b0000, 1'b1);
    chk("t4_valid_lo", 32'(bus.valid_o), 32'd0);
    chk("t4_ready_lo", 32'(bus.ready_o), 32'b1000);
    chk("t4_cnt1", 32'(dut.r_cnt), 32'd1);
    tick(1'b0, 4'b0101, 4'b0000, 1'b1);
    chk("t4_grant_held", 32'(bus.grant_o), 32'b1000);
    chk("t4_cnt_idle", 32'(dut.r_cnt), 32'd1);
    tick(1'b0, 4'b1101, 4'b0000, 1'b1);
    chk("t4_valid_back", 32'(bus.valid_o), 32'd1);
    tick(1'b0, 4'b1101, 4'b1000, 1'b1);
    chk("t4_cnt2", 32'(dut.r_cnt), 32'd2);
    chk("t4_last", 32'(bus.last_o), 32'd1);

    // Test 5: requester 0 stalled by downstream for 3 cycles.
    exp_grant.push_back(2'd0);
    exp_beat.push_back({2'd0, 1'b0});
    exp_beat.push_back({2'd0, 1'b0});
    tick(1'b0, 4'b0001, 4'b0000, 1'b1);
    chk("t5_idle", 32'(bus.busy_o), 32'd0);
    chk("t5_ptr_wrap", 32'(dut.r_ptr), 32'd0);
    tick(1'b0, 4'b0001, 4'b0000, 1'b1);
    chk("t5_sel", 32'(bus.sel_o), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick(1'b0, 4'b0001, 4'b0000, 1'b0);
      chk("t5_stall_valid", 32'(bus.valid_o), 32'd1);
      chk("t5_stall_cnt", 32'(dut.r_cnt), 32'd1);
      chk("t5_stall_sel", 32'(bus.sel_o), 32'd0);
      chk("t5_stall_ready", 32'(bus.ready_o), 32'd0);
    end
    tick(1'b0, 4'b0001, 4'b0000, 1'b1);
    chk("t5_resume_ready", 32'(bus.ready_o), 32'b0001);

    // Test 6: reset while locked with a live handshake.
    tick(1'b1, 4'b0001, 4'b0000, 1'b1);
    chk("t6_rst_valid", 32'(bus.valid_o), 32'd0);
    chk("t6_rst_ready", 32'(bus.ready_o), 32'd0);
    tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("t6_busy", 32'(bus.busy_o), 32'd0);
    chk("t6_grant", 32'(bus.grant_o), 32'd0);
    chk("t6_sel", 32'(bus.sel_o), 32'd0);
    chk("t6_ptr", 32'(dut.r_ptr), 32'd0);
    chk("t6_cnt", 32'(dut.r_cnt), 32'd0);

    tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
    chk("beat_queue_drained", 32'(exp_beat.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
